// File: rtl/fdc_pkg.sv
// Shared types and constants for the multi-channel frequency counter.
// Imported by the channel slice and the top level.
package fdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } fdc_state_t;

    localparam int FDC_SYNC_STAGES = 2;
    localparam int FDC_MIN_CH      = 1;
    localparam int FDC_MAX_CH      = 8;

endpackage

// File: rtl/fdc_edge_ch.sv
// One measured channel: synchronizer, rising-edge register and
// saturating edge counter with its sat bit.
import fdc_pkg::*;

module fdc_edge_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             sat_nxt
);

    logic [FDC_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                       prev_q, prev_d;
    logic                       edge_q, edge_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       sat_q, sat_d;

    // cnt_nxt includes the edge of the current cycle, so the top
    // can latch it in a closing cycle before the clear takes effect
    always_comb begin
        sync_d  = {sync_q[FDC_SYNC_STAGES-2:0], sig_in};
        prev_d  = sync_q[FDC_SYNC_STAGES-1];
        edge_d  = sync_q[FDC_SYNC_STAGES-1] & ~prev_q;
        cnt_nxt = cnt_q;
        sat_nxt = sat_q;
        if (cnt_en && edge_q) begin
            if (&cnt_q) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
        cnt_d = clr ? '0 : cnt_nxt;
        sat_d = clr ? 1'b0 : sat_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

endmodule

// File: rtl/fdc_multi_core.sv
// Multi-channel frequency-to-digital counter: gate FSM, ref sync,
// result registers and valid/ready result handshake.
import fdc_pkg::*;

module fdc_multi_core #(
    parameter  int N_CH   = 2,
    parameter  int CNT_W  = 16,
    parameter  int GATE_W = 16,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [N_CH-1:0]   sig_in,
    input  logic              ref_in,
    input  logic              mode,
    input  logic              cont,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_sat,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              overrun,
    output logic              busy
);

    if (N_CH < FDC_MIN_CH || N_CH > FDC_MAX_CH) begin : g_bad_n_ch
        $error("fdc_multi_core: N_CH out of range");
    end

    fdc_state_t state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  cont_q, cont_d;
    logic [GATE_W-1:0]     glen_q, glen_d;
    logic [GATE_W-1:0]     gate_q, gate_d;
    logic [FDC_SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
    logic                  ref_prev_q, ref_prev_d;
    logic                  ref_edge_q, ref_edge_d;
    logic [N_CH-1:0][CNT_W-1:0] res_q, res_d;
    logic [N_CH-1:0]       sat_q, sat_d;
    logic                  res_valid_q, res_valid_d;
    logic                  overrun_q, overrun_d;

    logic [N_CH-1:0][CNT_W-1:0] ch_cnt;
    logic [N_CH-1:0]       ch_sat;
    logic                  ch_en;
    logic                  ch_clr;
    logic                  close;
    logic                  start_ok;

    assign start_ok = start && ena && (state_q == IDLE);
    assign ch_en    = ena && (state_q == COUNT);
    assign close    = ch_en && (mode_q ? ref_edge_q
                                       : (gate_q == glen_q - 1'b1));
    assign ch_clr   = close || !ch_en;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        fdc_edge_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sig_in  (sig_in[g]),
            .clr     (ch_clr),
            .cnt_en  (ch_en),
            .cnt_nxt (ch_cnt[g]),
            .sat_nxt (ch_sat[g])
        );
    end

    always_comb begin
        ref_sync_d  = {ref_sync_q[FDC_SYNC_STAGES-2:0], ref_in};
        ref_prev_d  = ref_sync_q[FDC_SYNC_STAGES-1];
        ref_edge_d  = ref_sync_q[FDC_SYNC_STAGES-1] & ~ref_prev_q;
        state_d     = state_q;
        mode_d      = mode_q;
        cont_d      = cont_q;
        glen_d      = glen_q;
        gate_d      = gate_q;
        res_d       = res_q;
        sat_d       = sat_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mode_d    = mode;
                    cont_d    = cont;
                    glen_d    = (gate_len == '0) ? GATE_W'(1) : gate_len;
                    gate_d    = '0;
                    overrun_d = 1'b0;
                    state_d   = mode ? ARM : COUNT;
                end
            end
            ARM: begin
                if (ref_edge_q) begin
                    state_d = COUNT;
                    gate_d  = '0;
                end
            end
            COUNT: begin
                if (close) begin
                    gate_d = '0;
                    if (!cont_q) state_d = IDLE;
                end else begin
                    gate_d = gate_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!ena) state_d = IDLE;

        // a consume in the closing cycle keeps valid up without overrun
        if (close) begin
            res_d       = ch_cnt;
            sat_d       = ch_sat;
            res_valid_d = 1'b1;
            if (res_valid_q && !res_ready) overrun_d = 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cont_q      <= 1'b0;
            glen_q      <= '0;
            gate_q      <= '0;
            ref_sync_q  <= '0;
            ref_prev_q  <= 1'b0;
            ref_edge_q  <= 1'b0;
            res_q       <= '0;
            sat_q       <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cont_q      <= cont_d;
            glen_q      <= glen_d;
            gate_q      <= gate_d;
            ref_sync_q  <= ref_sync_d;
            ref_prev_q  <= ref_prev_d;
            ref_edge_q  <= ref_edge_d;
            res_q       <= res_d;
            sat_q       <= sat_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_sat  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = res_q[i];
                rd_sat  = sat_q[i];
            end
        end
    end

    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fdc_multi_core.sv
// Bench for fdc_multi_core: 16-bit and 4-bit instances on shared inputs,
// expected counts derived from the recorded input history.
module tb_fdc_multi_core;
    import fdc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, ena, ref_in, mode, cont, start;
    logic        rd_sel, res_ready;
    logic [1:0]  sig_in;
    logic [15:0] gate_len;
    logic [15:0] rd_data;
    logic        rd_sat, res_valid, overrun, busy;
    logic [3:0]  s_rd_data;
    logic        s_rd_sat, s_res_valid, s_overrun, s_busy;

    always #5 clk = ~clk;

    fdc_multi_core #(.N_CH(2), .CNT_W(16), .GATE_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in),
        .ref_in(ref_in), .mode(mode), .cont(cont), .start(start),
        .gate_len(gate_len), .rd_sel(rd_sel), .rd_data(rd_data),
        .rd_sat(rd_sat), .res_valid(res_valid), .res_ready(res_ready),
        .overrun(overrun), .busy(busy)
    );

    fdc_multi_core #(.N_CH(2), .CNT_W(4), .GATE_W(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in),
        .ref_in(ref_in), .mode(mode), .cont(cont), .start(start),
        .gate_len(gate_len), .rd_sel(rd_sel), .rd_data(s_rd_data),
        .rd_sat(s_rd_sat), .res_valid(s_res_valid), .res_ready(res_ready),
        .overrun(s_overrun), .busy(s_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // sig_h[n]/ref_h[n]: input values sampled at posedge number n
    logic [1:0] sig_h[$];
    logic       ref_h[$];
    always @(posedge clk) begin
        sig_h.push_back(sig_in);
        ref_h.push_back(ref_in);
    end

    // per: 0 idle low, 1 random, k>=2 square wave with a rise every k cycles
    int per[2];
    int ph[2];
    initial begin
        sig_in = 2'b00;
        per[0] = 0; per[1] = 0;
        ph[0]  = 0; ph[1]  = 0;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (per[ch] == 0)      sig_in[ch] = 1'b0;
                else if (per[ch] == 1) sig_in[ch] = 1'($urandom_range(0, 1));
                else sig_in[ch] = ((ph[ch] % per[ch]) < per[ch] / 2);
                ph[ch]++;
            end
        end
    end

    int  e16[2], e4[2];
    bit  s16[2], s4[2];
    bit  exp_valid = 1'b0;
    bit  exp_ovr   = 1'b0;

    // An input rise is seen by the counter three cycles later, so a window
    // counting on posedges a..b holds the rises applied at a-3..b-3.
    function automatic int rises(int ch, int a, int b);
        int c = 0;
        for (int n = a - 3; n <= b - 3; n++)
            if (n >= 1 && sig_h[n][ch] && !sig_h[n-1][ch]) c++;
        return c;
    endfunction

    function automatic int find_rise(int from);
        for (int n = (from < 1) ? 1 : from; n < ref_h.size(); n++)
            if (ref_h[n] && !ref_h[n-1]) return n;
        return -1;
    endfunction

    task automatic latch_exp(int a, int b, bit consumed);
        for (int ch = 0; ch < 2; ch++) begin
            int c;
            c = rises(ch, a, b);
            e16[ch] = (c > 65535) ? 65535 : c;
            s16[ch] = (c > 65535);
            e4[ch]  = (c > 15) ? 15 : c;
            s4[ch]  = (c > 15);
        end
        if (exp_valid && !consumed) exp_ovr = 1'b1;
        exp_valid = 1'b1;
    endtask

    task automatic check_all(string tag, bit exp_busy);
        check({tag, ".valid"}, res_valid, exp_valid);
        check({tag, ".s_valid"}, s_res_valid, exp_valid);
        check({tag, ".ovr"}, overrun, exp_ovr);
        check({tag, ".s_ovr"}, s_overrun, exp_ovr);
        check({tag, ".busy"}, busy, exp_busy);
        check({tag, ".s_busy"}, s_busy, exp_busy);
        for (int ch = 0; ch < 2; ch++) begin
            rd_sel = 1'(ch);
            #1;
            check($sformatf("%s.d%0d", tag, ch), rd_data, e16[ch]);
            check($sformatf("%s.sat%0d", tag, ch), rd_sat, s16[ch]);
            check($sformatf("%s.s_d%0d", tag, ch), s_rd_data, e4[ch]);
            check($sformatf("%s.s_sat%0d", tag, ch), s_rd_sat, s4[ch]);
        end
    endtask

    // returns on the negedge that follows posedge p
    task automatic wait_to(int p);
        while (sig_h.size() < p + 1) @(negedge clk);
    endtask

    task automatic do_start(bit m, bit c, int gl, output int s);
        mode     = m;
        cont     = c;
        gate_len = 16'(gl);
        start    = 1'b1;
        s        = sig_h.size();
        @(negedge clk);
        start    = 1'b0;
        mode     = 1'($urandom);
        cont     = 1'($urandom);
        gate_len = 16'($urandom);
        exp_ovr  = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_valid = 1'b0;
        check("consume", res_valid, 0);
    endtask

    task automatic pulse_ref();
        ref_in = 1'b1;
        @(negedge clk);
        ref_in = 1'b0;
    endtask

    task automatic ext_win(int s, output int a, output int b);
        int n1, n2;
        n1 = find_rise(s - 2);
        n2 = (n1 < 0) ? -1 : find_rise(n1 + 1);
        check("ext_ref_seen", (n2 >= 0), 1);
        if (n2 < 0) begin
            a = s + 1;
            b = s + 1;
        end else begin
            a = n1 + 4;
            b = n2 + 3;
        end
    endtask

    initial begin
        int s, a, b, gl;
        rst_n = 1'b0; ena = 1'b1; ref_in = 1'b0; mode = 1'b0;
        cont = 1'b0; start = 1'b0; rd_sel = 1'b0; res_ready = 1'b0;
        gate_len = 16'd0;
        for (int ch = 0; ch < 2; ch++) begin
            e16[ch] = 0; e4[ch] = 0; s16[ch] = 0; s4[ch] = 0;
        end
        repeat (3) @(negedge clk);
        check_all("reset", 1'b0);
        rst_n = 1'b1;

        // internal gate, single shot
        per[0] = 2; per[1] = 0;
        repeat (5) @(negedge clk);
        do_start(1'b0, 1'b0, 10, s);
        wait_to(s + 9);
        check("int_pre_valid", res_valid, 0);
        wait_to(s + 10);
        latch_exp(s + 1, s + 10, 1'b0);
        check_all("int", 1'b0);
        check("int_idle", int'(u_dut.state_q), int'(IDLE));
        rd_sel = 1'b0; #1;
        check("int_five", rd_data, 5);

        // saturation of the 4-bit instance
        consume();
        per[0] = 0; per[1] = 2;
        do_start(1'b0, 1'b0, 100, s);
        wait_to(s + 100);
        latch_exp(s + 1, s + 100, 1'b0);
        check_all("sat", 1'b0);
        rd_sel = 1'b1; #1;
        check("sat_fifteen", s_rd_data, 15);
        check("sat_bit", s_rd_sat, 1);

        // external gate, previous result left unconsumed
        per[0] = 4; per[1] = 0;
        do_start(1'b1, 1'b0, 0, s);
        check("ext_arm", int'(u_dut.state_q), int'(ARM));
        check("ext_busy", busy, 1);
        repeat (5) @(negedge clk);
        pulse_ref();
        repeat (39) @(negedge clk);
        pulse_ref();
        ext_win(s, a, b);
        wait_to(b);
        latch_exp(a, b, 1'b0);
        check_all("ext", 1'b0);
        rd_sel = 1'b0; #1;
        check("ext_ten", rd_data, 10);

        // continuous with overrun, then consume in a close cycle
        consume();
        per[0] = 1; per[1] = 2;
        do_start(1'b0, 1'b1, 8, s);
        wait_to(s + 8);
        latch_exp(s + 1, s + 8, 1'b0);
        check_all("cont_w1", 1'b1);
        wait_to(s + 16);
        latch_exp(s + 9, s + 16, 1'b0);
        check_all("cont_w2", 1'b1);
        wait_to(s + 23);
        res_ready = 1'b1;
        wait_to(s + 24);
        res_ready = 1'b0;
        latch_exp(s + 17, s + 24, 1'b1);
        check_all("cont_w3", 1'b1);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        check("cont_stop", busy, 0);
        do_start(1'b0, 1'b1, 8, s);
        check("ovr_cleared", overrun, 0);
        wait_to(s + 7);
        res_ready = 1'b1;
        wait_to(s + 8);
        res_ready = 1'b0;
        latch_exp(s + 1, s + 8, 1'b1);
        check_all("cont_cons", 1'b1);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;

        // reset in the middle of a window
        per[0] = 2; per[1] = 2;
        do_start(1'b0, 1'b0, 20, s);
        wait_to(s + 5);
        rst_n = 1'b0;
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            e16[ch] = 0; e4[ch] = 0; s16[ch] = 0; s4[ch] = 0;
        end
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        check_all("rst_mid", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_start(1'b0, 1'b0, 20, s);
        wait_to(s + 20);
        latch_exp(s + 1, s + 20, 1'b0);
        check_all("rst_after", 1'b0);

        // enable abort keeps the previous result
        do_start(1'b0, 1'b0, 30, s);
        wait_to(s + 10);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        check("abort_state", int'(u_dut.state_q), int'(IDLE));
        check_all("abort", 1'b0);
        wait_to(s + 40);
        check_all("abort_hold", 1'b0);

        // gate_len of zero behaves as one
        consume();
        per[0] = 1; per[1] = 2;
        do_start(1'b0, 1'b0, 0, s);
        wait_to(s + 1);
        latch_exp(s + 1, s + 1, 1'b0);
        check_all("glen0", 1'b0);

        // randomized windows
        for (int it = 0; it < 12; it++) begin
            per[0] = int'($urandom_range(0, 5));
            per[1] = int'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) consume();
            if ($urandom_range(0, 3) == 0) begin
                do_start(1'b1, 1'b0, 0, s);
                repeat ($urandom_range(0, 6)) @(negedge clk);
                pulse_ref();
                repeat ($urandom_range(3, 30)) @(negedge clk);
                pulse_ref();
                ext_win(s, a, b);
                wait_to(b);
                latch_exp(a, b, 1'b0);
                check_all($sformatf("rnd%0d_ext", it), 1'b0);
            end else begin
                gl = int'($urandom_range(0, 40));
                do_start(1'b0, 1'b0, gl, s);
                b = s + ((gl == 0) ? 1 : gl);
                wait_to(b);
                latch_exp(s + 1, b, 1'b0);
                check_all($sformatf("rnd%0d_int", it), 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fdc_multi_core.md
# fdc_multi_core

Parametrised multi-channel frequency-to-digital counter core, the successor to the single-channel FDC datapath in `tt_um_fdc_chip`. Each channel counts rising edges of an asynchronous input over a gate window. The window is either an internal programmable cycle count or the interval between two external reference pulses. Latched results are read through a valid/ready handshake with a channel select, and overrun is reported. The block sits between the pad-level `ui_in` inputs and the output mux of the top wrapper.

## Interface
- `N_CH`, default 2: number of measured channels (1..8).
- `CNT_W`, default 16: width of each edge counter and result.
- `GATE_W`, default 16: width of the internal gate length.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `ena` input, 1 bit: design enable; low aborts any window and forces IDLE.
- `sig_in` input, N_CH bits: asynchronous measured signals.
- `ref_in` input, 1 bit: asynchronous external gate pulse, used in external mode.
- `mode` input, 1 bit: 0 selects internal gate, 1 selects external (ref-to-ref) gate.
- `cont` input, 1 bit: 1 is continuous measurement, 0 is single-shot.
- `start` input, 1 bit: one-cycle pulse that starts a measurement from IDLE.
- `gate_len` input, GATE_W bits: internal window length in clk cycles; 0 is treated as 1.
- `rd_sel` input, max(1,$clog2(N_CH)) bits: channel to present on `rd_data`.
- `rd_data` output, CNT_W bits: latched result of channel `rd_sel`, combinational mux.
- `rd_sat` output, 1 bit: saturation flag of channel `rd_sel`.
- `res_valid` output, 1 bit: result set available.
- `res_ready` input, 1 bit: consumer accepts the result set.
- `overrun` output, 1 bit: sticky flag; an unconsumed result was overwritten.
- `busy` output, 1 bit: high in ARM or COUNT.

## Operation
- FSM states:
  - IDLE: moves on `start` && `ena`. Goes to COUNT if `mode`=0, or to ARM if `mode`=1.
  - ARM: waits for the first synchronized `ref_in` rising edge, then goes to COUNT.
  - COUNT: the gate window is open.
- Window close condition:
  - Internal mode: the gate counter reaches `gate_len` cycles.
  - External mode: the next synchronized `ref_in` rising edge.
- On close:
  - All channel counts are copied to result registers and the live counters are cleared.
  - If `cont`=1, the next window opens in the same cycle; otherwise the FSM returns to IDLE.
- `mode`, `cont` and `gate_len` are sampled at `start`. Changes during a measurement are ignored.
- Counters saturate at 2^CNT_W−1 and set a per-channel sat bit, which is latched with the result.
- An edge detected in the closing cycle is counted in the closing window.
- Handshake: `res_valid`&&`res_ready` consumes the result set.
- New result while `res_valid`=1 and not being consumed: the result is overwritten, `overrun` is set, and `res_valid` stays 1.
- New result in the same cycle as a consume: `res_valid` stays 1 and `overrun` is not set.
- `overrun` clears on reset or on an accepted `start`.
- `ena` low: the FSM goes to IDLE and live counters clear. Result registers, `res_valid` and `overrun` are held.

## Timing
- Reset values: state IDLE; all counters, results and sat bits 0; `res_valid`=0, `overrun`=0, `busy`=0, `rd_data`=0.
- `sig_in` and `ref_in` pass through a 2-flop synchronizer plus a rising-edge register, so detection happens 3 cycles after the input edge.
- Window close at cycle t: `res_valid` is 1 and results are visible from t+1.
- `busy` rises the cycle after `start`.
- Internal window length is exactly `gate_len` cycles, counted from the cycle after `start`.
- `rst_n` asserted mid-window: everything returns to reset values immediately (asynchronous), with no partial result.

## Structure
- `fdc_pkg` holds:
  - the state enum `fdc_state_t` {IDLE, ARM, COUNT};
  - `FDC_SYNC_STAGES`=2;
  - the `N_CH` legality check constants.
- Sub-module `fdc_edge_ch` contains one channel's synchronizer, edge detector, saturating counter and sat bit. It takes `clr` and `cnt_en` inputs and is instantiated N_CH times via generate.
- The top level contains the FSM, gate counter, ref synchronizer, result registers and handshake.

## Test plan
- Internal gate: `mode`=0, `cont`=0, `gate_len`=10; `sig_in[0]` toggles every cycle; `start`.
  - Required: `rd_data`=5 on ch0, `res_valid` one cycle after close, FSM back in IDLE, `busy`=0.
- Saturation: CNT_W=4, `gate_len`=100, ch1 edge every 2 cycles.
  - Required: `rd_data`=15 and `rd_sat`=1 on ch1; ch0 idle gives 0.
- External gate: `mode`=1; `ref_in` pulses 40 cycles apart; `sig_in[0]` edge every 4 cycles.
  - Required: FSM passes through ARM; `rd_data`=10.
- Continuous with overrun: `cont`=1, `gate_len`=8, `res_ready`=0 for two windows.
  - Required: `overrun`=1 and the second result is shown.
  - Then `res_ready`=1 exactly in a close cycle: `res_valid` stays 1 and `overrun` does not re-trigger after being cleared by `start`.
- Reset mid-window: `rst_n`=0 at cycle 5 of a 20-cycle window.
  - Required: all outputs 0 immediately; after release and a new `start`, the count is correct.
- Enable abort: `ena`=0 mid-window.
  - Required: FSM goes to IDLE, previous results and `res_valid` are held, no new result.
